sr_cmd_sequencer: RTL and testbench
===================================

// Module: sr_cmd_sequencer
// PURPOSE
//   Upstream command stage for the lab SR flip-flop: turns two raw push-button inputs (set, reset)
//   into clean, single-shot 2-bit command codes on s/r. Synchronizes, debounces and edge-detects
//   each button, arbitrates conflicts, then issues each command for a fixed pulse and enforces a
//   quiet gap. Code 2'b11 (high-Z) is never emitted.
// PARAMETERS
//   DB_CYCLES     16  debounce: consecutive stable cycles before a level is accepted (>=2)
//   PULSE_CYCLES   1  cycles a command code is held on s/r (>=1)
//   GAP_CYCLES     2  cycles of 2'b00 forced after each command (>=0)
// PORTS
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   btn_set    in   1  raw, asynchronous set button
//   btn_rst    in   1  raw, asynchronous reset button
//   s          out  2  set-port command: 2'b00 hold, 2'b10 drive q=1
//   r          out  2  reset-port command: 2'b00 hold, 2'b01 drive q=0
//   busy       out  1  high in ISSUE, GAP or LOCK
//   conflict   out  1  high while in LOCK
// BEHAVIOUR
//   Reset: async assert, sync release by clock; s=2'b00, r=2'b00, busy=0, conflict=0,
//     debounced levels=0, counters=0, FSM=IDLE.
//   Sync: each button through 2 flops (sync_*); raw input invisible for 2 cycles.
//   Debounce (per channel): if sync != stable, count++; else count=0. When count reaches
//     DB_CYCLES-1 with sync still != stable: stable<=sync, count<=0. Counter width $clog2(DB_CYCLES)+1.
//   Edge: req_set/req_rst = one-cycle pulse on stable 0->1. Falling edges ignored.
//   FSM (one state register):
//     IDLE : req_set & req_rst -> LOCK; req_set -> ISSUE(SET); req_rst -> ISSUE(RST); else stay.
//     ISSUE: outputs the latched command PULSE_CYCLES cycles, then -> GAP (GAP_CYCLES=0 -> IDLE).
//     GAP  : s=r=2'b00 for GAP_CYCLES cycles -> IDLE.
//     LOCK : s=r=2'b00, conflict=1; exit to IDLE only when both stable levels are 0.
//   Outputs registered: the first command cycle is the cycle after the req pulse in IDLE.
//     Total latency raw press -> s/r change = 2 (sync) + DB_CYCLES + 1 (edge) + 1 cycles.
//   SET: s=2'b10, r=2'b00. RST: s=2'b00, r=2'b01. Never both non-zero; never 2'b11.
//   Requests arriving in ISSUE/GAP/LOCK are dropped (no queue); a held button does not re-fire.
//   Simultaneous req_set and req_rst in IDLE: no command, enter LOCK (conflict flagged).
//   One req in IDLE while other button already stably high: the edge is honoured normally.
//   Reset mid-ISSUE: outputs return to 2'b00 immediately (async); no partial pulse resumes.
//   Pulse/gap counters saturate-free: width $clog2(max(PULSE_CYCLES,GAP_CYCLES)+1).
// CONFIGURATION
//   SR_CMD_REPEAT_EN defined: while the originating button remains stably high after GAP,
//     FSM re-enters ISSUE with the same command (auto-repeat, period PULSE_CYCLES+GAP_CYCLES);
//     release or a stable-high on the other button stops repeat (other button -> LOCK).
//   SR_CMD_REPEAT_EN undefined: GAP always -> IDLE; one command per press. Default: undefined.
// TESTING
//   Use DB_CYCLES=4, PULSE_CYCLES=2, GAP_CYCLES=3 unless stated.
//   1 Reset: rst_n=0 mid-run with btn_set=1 -> s=r=2'b00, busy=0, conflict=0 same cycle
//     without clock edge; release and hold btn_set -> exactly one SET pulse after debounce.
//   2 Clean set: btn_set 0->1 held 20 cycles -> s=2'b10 for exactly 2 cycles, starting cycle
//     2+4+1+1=8 after the press, r=2'b00 throughout, then 3 cycles 00, busy high for 5 cycles.
//   3 Bounce: btn_rst toggles every cycle for 10 cycles then holds 1 -> no command during
//     toggling; single r=2'b01 pulse after stable acceptance.
//   4 Conflict: btn_set and btn_rst rise same cycle -> no s/r activity, conflict=1 until both
//     released and debounced, then conflict=0, busy=0; new press works.
//   5 Drop: press btn_rst during a SET's GAP -> reset pulse dropped; s=r=2'b00 after gap.
//   6 With SR_CMD_REPEAT_EN, hold btn_set 30 cycles -> SET pulses repeating every 5 cycles;
//     without the macro -> one pulse only. Assert s!=2'b11, r!=2'b11, !(s!=0 && r!=0) always.

Source files
------------

// File: rtl/sr_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// sr_cmd_sequencer_if
//   Bundles the push-button inputs and the command/status outputs of the
//   SR command sequencer.
//   Signals:
//     btn_set   raw, asynchronous set button
//     btn_rst   raw, asynchronous reset button
//     s[1:0]    set-port command   (2'b00 hold, 2'b10 drive q=1)
//     r[1:0]    reset-port command (2'b00 hold, 2'b01 drive q=0)
//     busy      sequencer is in ISSUE, GAP or LOCK
//     conflict  sequencer is in LOCK
//   Modports:
//     slave  - the sequencer (consumes buttons, drives commands)
//     master - the environment (drives buttons, observes commands)
// ---------------------------------------------------------------------------
interface sr_cmd_sequencer_if;
  logic       btn_set;
  logic       btn_rst;
  logic [1:0] s;
  logic [1:0] r;
  logic       busy;
  logic       conflict;

  modport slave  (input btn_set, btn_rst, output s, r, busy, conflict);
  modport master (output btn_set, btn_rst, input s, r, busy, conflict);
endinterface

// File: rtl/sr_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// sr_cmd_sequencer
//   Turns two raw push buttons into clean single-shot SR command codes.
//   Each button is synchronised (2 flops), debounced (DB_CYCLES stable
//   cycles), and rising-edge detected. An FSM arbitrates the requests and
//   issues a command for PULSE_CYCLES cycles followed by GAP_CYCLES quiet
//   cycles. Simultaneous requests park the FSM in LOCK until both buttons
//   are released. Code 2'b11 is never produced on s or r.
//   Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset (assert async, release sync)
//     cmd     sr_cmd_sequencer_if.slave: btn_set, btn_rst in; s, r, busy,
//             conflict out (all outputs registered)
//   Optional feature macro: SR_CMD_REPEAT_EN
//     defined   - a button still held at the end of GAP re-issues its
//                 command (auto-repeat); the other button held -> LOCK.
//     undefined - one command per press (default).
// ---------------------------------------------------------------------------
module sr_cmd_sequencer #(
  parameter int DB_CYCLES    = 16,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sr_cmd_sequencer_if.slave cmd
);

  localparam int             DBW        = $clog2(DB_CYCLES) + 1;
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
  localparam int             CNT_MAX    = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int             CW         = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]  PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]  GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, LOCK} state_t;

  // Reset bridge: assertion reaches every flop at once, release is aligned
  // to clk so no flop leaves reset on a different edge than its neighbours.
  logic [1:0] rst_sync_reg;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_int_n = rst_sync_reg[1];

  // Channel 0 = set button, channel 1 = reset button.
  logic [1:0] btn;
  logic [1:0] level;  // debounced levels
  logic [1:0] req;    // one-cycle pulse on debounced 0->1

  assign btn = {cmd.btn_rst, cmd.btn_set};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic           sync1_reg;
    logic           sync2_reg;
    logic           stable_reg;
    logic           stable_d_reg;
    logic           req_reg;
    logic [DBW-1:0] db_cnt_reg;

    always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
        sync1_reg    <= 1'b0;
        sync2_reg    <= 1'b0;
        stable_reg   <= 1'b0;
        stable_d_reg <= 1'b0;
        req_reg      <= 1'b0;
        db_cnt_reg   <= '0;
      end else begin
        sync1_reg <= btn[gi];
        sync2_reg <= sync1_reg;
        // Any cycle that agrees with the accepted level restarts the count,
        // so bouncing never accumulates towards acceptance.
        if (sync2_reg != stable_reg) begin
          if (db_cnt_reg == DB_LAST) begin
            stable_reg <= sync2_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end else begin
          db_cnt_reg <= '0;
        end
        stable_d_reg <= stable_reg;
        req_reg      <= stable_reg & ~stable_d_reg;
      end
    end

    assign level[gi] = stable_reg;
    assign req[gi]   = req_reg;
  end

  state_t        state_reg, state_next;
  state_t        after_gap;
  logic          cmd_set_reg, cmd_set_next;  // latched command: 1 SET, 0 RST
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    s_reg, r_reg, s_next, r_next;
  logic          busy_reg, conflict_reg;

  // Where the FSM goes once the quiet gap has elapsed.
  always_comb begin
    after_gap = IDLE;
`ifdef SR_CMD_REPEAT_EN
    if (cmd_set_reg ? level[1] : level[0])
      after_gap = LOCK;
    else if (cmd_set_reg ? level[0] : level[1])
      after_gap = ISSUE;
`endif
  end

  always_comb begin
    state_next   = state_reg;
    cmd_set_next = cmd_set_reg;
    cnt_next     = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (req[0] && req[1]) begin
          state_next = LOCK;
        end else if (req[0]) begin
          state_next   = ISSUE;
          cmd_set_next = 1'b1;
        end else if (req[1]) begin
          state_next   = ISSUE;
          cmd_set_next = 1'b0;
        end
      end
      ISSUE: begin
        if (cnt_reg == PULSE_LAST) begin
          cnt_next   = '0;
          state_next = (GAP_CYCLES == 0) ? after_gap : GAP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = after_gap;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      LOCK: begin
        cnt_next = '0;
        if (!level[0] && !level[1]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Outputs are decoded from the next state so they come straight off flops.
    s_next = (state_next == ISSUE &&  cmd_set_next) ? 2'b10 : 2'b00;
    r_next = (state_next == ISSUE && !cmd_set_next) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg    <= IDLE;
      cmd_set_reg  <= 1'b0;
      cnt_reg      <= '0;
      s_reg        <= 2'b00;
      r_reg        <= 2'b00;
      busy_reg     <= 1'b0;
      conflict_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cmd_set_reg  <= cmd_set_next;
      cnt_reg      <= cnt_next;
      s_reg        <= s_next;
      r_reg        <= r_next;
      busy_reg     <= (state_next != IDLE);
      conflict_reg <= (state_next == LOCK);
    end
  end

  assign cmd.s        = s_reg;
  assign cmd.r        = r_reg;
  assign cmd.busy     = busy_reg;
  assign cmd.conflict = conflict_reg;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sr_cmd_sequencer
//   Directed bench for sr_cmd_sequencer with DB_CYCLES=4, PULSE_CYCLES=2,
//   GAP_CYCLES=3 (default build, SR_CMD_REPEAT_EN undefined).
//   A run-length table holds {btn_set, btn_rst, cycles, expected s, r, busy,
//   conflict}; each cycle drives the buttons #1 after a rising edge and
//   checks the outputs #1 after the next rising edge. A press driven on
//   step 1 reaches s/r on step 2+4+1+1 = 8. The async-reset case is a
//   hand-written sequence after the table.
// ---------------------------------------------------------------------------
module tb_sr_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  sr_cmd_sequencer_if bus();

  sr_cmd_sequencer #(
    .DB_CYCLES   (4),
    .PULSE_CYCLES(2),
    .GAP_CYCLES  (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cmd  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       bs;
    logic       br;
    int         n;
    logic [1:0] s;
    logic [1:0] r;
    logic       busy;
    logic       conf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic bs, input logic br, input int n,
                     input logic [1:0] s, input logic [1:0] r,
                     input logic busy, input logic conf);
    vec_t v;
    v.bs = bs; v.br = br; v.n = n;
    v.s = s; v.r = r; v.busy = busy; v.conf = conf;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s idx=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic bs, input logic br);
    bus.btn_set = bs;
    bus.btn_rst = br;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {2'b00, bus.s, bus.r, bus.busy, bus.conflict};
  endfunction

  // Code legality on every cycle.
  always @(negedge clk) begin
    total++;
    if (bus.s == 2'b11 || bus.r == 2'b11 || (bus.s != 2'b00 && bus.r != 2'b00)) begin
      bad++;
      $display("FAIL legal_codes t=%0t got s=%b r=%b want no 11 and not both active",
               $time, bus.s, bus.r);
    end
  end

  int first_hit;
  int hits;
  int r_hits;

  initial begin
    rst_n       = 1'b0;
    bus.btn_set = 1'b0;
    bus.btn_rst = 1'b0;
    #1;
    check("reset_state", 0, outs(), 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Let the reset bridge release.
    add(0, 0, 4, 2'b00, 2'b00, 0, 0);
    // Clean set, held 30 cycles: one 2-cycle pulse, 3-cycle gap, no re-fire.
    add(1, 0, 7,  2'b00, 2'b00, 0, 0);
    add(1, 0, 2,  2'b10, 2'b00, 1, 0);
    add(1, 0, 3,  2'b00, 2'b00, 1, 0);
    add(1, 0, 18, 2'b00, 2'b00, 0, 0);
    add(0, 0, 8,  2'b00, 2'b00, 0, 0);
    // Bounce on reset button for 10 cycles, then hold from step 11.
    for (int k = 0; k < 5; k++) begin
      add(0, 1, 1, 2'b00, 2'b00, 0, 0);
      add(0, 0, 1, 2'b00, 2'b00, 0, 0);
    end
    add(0, 1, 7, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2, 2'b00, 2'b01, 1, 0);
    add(0, 1, 3, 2'b00, 2'b00, 1, 0);
    add(0, 1, 3, 2'b00, 2'b00, 0, 0);
    add(0, 0, 8, 2'b00, 2'b00, 0, 0);
    // Conflict: both rise together; LOCK until both debounced low.
    add(1, 1, 7, 2'b00, 2'b00, 0, 0);
    add(1, 1, 3, 2'b00, 2'b00, 1, 1);
    add(0, 0, 6, 2'b00, 2'b00, 1, 1);
    add(0, 0, 3, 2'b00, 2'b00, 0, 0);
    // Set press, reset press whose request lands in the gap: dropped.
    add(1, 0, 4, 2'b00, 2'b00, 0, 0);
    add(1, 1, 3, 2'b00, 2'b00, 0, 0);
    add(1, 1, 2, 2'b10, 2'b00, 1, 0);
    add(1, 1, 3, 2'b00, 2'b00, 1, 0);
    add(1, 1, 8, 2'b00, 2'b00, 0, 0);
    add(0, 0, 8, 2'b00, 2'b00, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].bs, tbl[i].br);
        check("vec", i, outs(),
              {2'b00, tbl[i].s, tbl[i].r, tbl[i].busy, tbl[i].conf});
      end
      $display("vec %0d set=%0b rst=%0b cycles=%0d s=%b r=%b busy=%0b conflict=%0b",
               i, tbl[i].bs, tbl[i].br, tbl[i].n, tbl[i].s, tbl[i].r,
               tbl[i].busy, tbl[i].conf);
    end

    // Async reset in the middle of a SET pulse, button kept pressed.
    for (int k = 1; k <= 8; k++) step(1, 0);
    check("mid_issue", 8, outs(), 8'h22);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", 0, outs(), 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("in_rst", 0, outs(), 8'h00);
    rst_n = 1'b1;
    // Two edges of reset bridge, then the normal 8-step press latency.
    first_hit = 0;
    hits      = 0;
    r_hits    = 0;
    for (int k = 1; k <= 25; k++) begin
      step(1, 0);
      if (bus.s == 2'b10) begin
        hits++;
        if (first_hit == 0) first_hit = k;
      end
      if (bus.r != 2'b00) r_hits++;
    end
    check("post_rst_first", 0, 8'(first_hit), 8'd10);
    check("post_rst_count", 0, 8'(hits), 8'd2);
    check("post_rst_r", 0, 8'(r_hits), 8'd0);
    $display("post-reset press: first pulse step=%0d pulse cycles=%0d", first_hit, hits);
    for (int k = 0; k < 8; k++) step(0, 0);
    check("final_idle", 0, outs(), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
